color_extract_ctrl: RTL and testbench
=====================================

# color_extract_ctrl

Sequencer for the reference-colour extraction path of the HSV tracking pipeline. On a user request it arms on the next frame start and accumulates H, S and V over a fixed screen window for several frames. It then divides the three sums one after another through a single shared serial divider, and publishes a reference colour plus low/high match bounds. The block sits between the video timing counters / HSV converter and the binary thresholding stage.

## Interface
Parameters:
- WIN_X0, 296, first window column (inclusive)
- WIN_Y0, 216, first window row (inclusive)
- WIN_W, 48, window width in pixels
- WIN_H, 48, window height in lines
- FRAMES, 4, frames accumulated per extraction (1..8)
- TOL, 16, per-channel tolerance added to / subtracted from the reference (0..255)

Ports:
- PClk  in  1  pixel clock; only clock
- Rst  in  1  synchronous, active-high reset
- VtcHCnt  in  12  horizontal pixel counter
- VtcVCnt  in  12  vertical line counter
- HSV24  in  24  pixel {H[23:16], S[15:8], V[7:0]}, aligned with the counters
- BtnExtract  in  1  extraction request (level; rising edge is used)
- SwClear  in  1  clear request (level)
- Busy  out  1  high from accepted request until results load
- Done  out  1  one-cycle pulse when new results load
- RefValid  out  1  high while outputs hold an extracted colour
- HsvRef  out  24  averaged reference {H,S,V}
- HsvLow  out  24  per-channel lower bound
- HsvHigh  out  24  per-channel upper bound

## Operation
- Frame start (FS) is VtcHCnt==0 && VtcVCnt==0. In-window means WIN_X0 ≤ VtcHCnt < WIN_X0+WIN_W and WIN_Y0 ≤ VtcVCnt < WIN_Y0+WIN_H.
- Request: BtnExtract is registered once. Rise = current 1 and previous 0. A rise while Busy is ignored.
- States:
  - IDLE: on a rise, go to ARM.
  - ARM: clear the three 24-bit sums and the frame counter. At FS go to ACCUM. The FS cycle is already accumulated if it is in-window.
  - ACCUM: on each in-window cycle, add each 8-bit channel zero-extended to its sum. Each FS increments the frame counter. At the FS where the counter reaches FRAMES, go to DIV. That FS pixel is not accumulated.
  - DIV: one restoring divider, 1 quotient bit per cycle, 24 cycles per channel. Order is H, then S, then V. The divisor is the constant N = WIN_W·WIN_H·FRAMES. Quotients truncate and are stored as 8 bits, since the quotient is ≤255 by construction.
  - LOAD: one cycle. Register HsvRef, HsvLow, HsvHigh. Pulse Done, set RefValid, clear Busy, return to IDLE.
- Bounds per channel: low = max(ref−TOL, 0), high = min(ref+TOL, 255).
- SwClear has highest priority over everything except Rst. While high, the FSM is forced to IDLE and any extraction in progress is discarded. Outputs are forced to cleared values; no Done pulse.
- Cleared values (also reset values): HsvRef=24'hFFFFFF, HsvLow=24'hFFFFFF, HsvHigh=24'h000000 (empty range, no pixel matches), RefValid=0, Busy=0, Done=0.
- Rst mid-operation: same as SwClear, and the request edge register is also cleared.

## Timing
- Busy rises the cycle after the request rise is detected.
- Accumulation covers exactly FRAMES full frames, from the arming FS up to (excluding) the FRAMES-th following FS.
- From the terminating FS: 72 DIV cycles, then LOAD. Done/RefValid/outputs update 73 cycles after the terminating FS.
- Outputs hold their values between LOADs. A new extraction leaves old outputs valid until its LOAD.
- A request rise in the same cycle as SwClear is dropped.

## Configuration
- COLOR_CTRL_HUE_WRAP_EN defined: the hue bounds wrap modulo 256 (low = ref−TOL mod 256, high = ref+TOL mod 256). Low > high then denotes a wrapped range. S and V still saturate.
- Undefined: all three channels saturate as above.

## Test plan
- Constant HSV24=24'h4080C0, pulse BtnExtract → after FRAMES frames plus 73 cycles, Done for 1 cycle. HsvRef=24'h4080C0, HsvLow=24'h3070B0, HsvHigh=24'h5090D0, RefValid=1.
- Constant 24'h05FA80 → HsvLow=24'h00EA70, HsvHigh=24'h15FF90. With COLOR_CTRL_HUE_WRAP_EN: HsvLow=24'hF5EA70, HsvHigh=24'h15FF90.
- Window value 24'h102030 with 24'hFFFFFF everywhere else → HsvRef=24'h102030 (out-of-window pixels and boundary columns 295/344, rows 215/264 are excluded).
- Alternate frames 24'h000000 and 24'h030303 with FRAMES=4 → HsvRef=24'h010101 (truncation: 6/4=1).
- Assert SwClear mid-ACCUM → Busy=0 next cycle, outputs at cleared values, no Done. A fresh request then completes normally.
- Second BtnExtract rise during DIV → ignored; exactly one Done pulse.

Source files
------------

// File: rtl/color_extract_ctrl.sv
// Reference-colour extraction sequencer: arms on frame start, sums H/S/V over a window
// for FRAMES frames, then divides through one serial divider. Build macro: COLOR_CTRL_HUE_WRAP_EN.
module color_extract_ctrl #(
  parameter int WIN_X0 = 296,
  parameter int WIN_Y0 = 216,
  parameter int WIN_W  = 48,
  parameter int WIN_H  = 48,
  parameter int FRAMES = 4,
  parameter int TOL    = 16
) (
  input  logic        PClk,
  input  logic        Rst,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  input  logic [23:0] HSV24,
  input  logic        BtnExtract,
  input  logic        SwClear,
  output logic        Busy,
  output logic        Done,
  output logic        RefValid,
  output logic [23:0] HsvRef,
  output logic [23:0] HsvLow,
  output logic [23:0] HsvHigh
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_DIV   = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;

  localparam logic [11:0] X_LO     = 12'(WIN_X0);
  localparam logic [11:0] X_HI     = 12'(WIN_X0 + WIN_W);
  localparam logic [11:0] Y_LO     = 12'(WIN_Y0);
  localparam logic [11:0] Y_HI     = 12'(WIN_Y0 + WIN_H);
  localparam logic [3:0]  FRM_LAST = 4'(FRAMES);
  localparam logic [23:0] DIVISOR  = 24'(WIN_W * WIN_H * FRAMES);
  localparam logic [7:0]  TOL_B    = 8'(TOL);

  function automatic logic [7:0] sat_low(input logic [7:0] ref_v);
    if (ref_v >= TOL_B) begin
      return ref_v - TOL_B;
    end else begin
      return 8'd0;
    end
  endfunction

  function automatic logic [7:0] sat_high(input logic [7:0] ref_v);
    logic [8:0] sum_v;
    sum_v = {1'b0, ref_v} + {1'b0, TOL_B};
    if (sum_v > 9'd255) begin
      return 8'hFF;
    end else begin
      return sum_v[7:0];
    end
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic        btn_prev_r;
  logic        rise_s;
  logic        fs_s;
  logic        in_win_s;
  logic        term_fs_s;
  logic [3:0]  frm_r;
  logic [3:0]  frm_inc_s;
  logic [23:0] sum_h_r;
  logic [23:0] sum_s_r;
  logic [23:0] sum_v_r;
  logic [23:0] dvd_r;
  logic [23:0] rem_r;
  logic [24:0] trial_s;
  logic [23:0] rem_nxt_s;
  logic        q_bit_s;
  logic [7:0]  q_r;
  logic [7:0]  q_nxt_s;
  logic [4:0]  bit_r;
  logic [1:0]  ch_r;
  logic        div_last_s;
  logic [23:0] avg_r;
  logic [7:0]  hue_low_s;
  logic [7:0]  hue_high_s;
  logic [23:0] low_s;
  logic [23:0] high_s;

  assign fs_s       = (VtcHCnt == 12'd0) && (VtcVCnt == 12'd0);
  assign in_win_s   = (VtcHCnt >= X_LO) && (VtcHCnt < X_HI) &&
                      (VtcVCnt >= Y_LO) && (VtcVCnt < Y_HI);
  assign rise_s     = BtnExtract && !btn_prev_r;
  assign frm_inc_s  = frm_r + 4'd1;
  assign term_fs_s  = fs_s && (frm_inc_s == FRM_LAST);
  assign div_last_s = (ch_r == 2'd2) && (bit_r == 5'd23);

  // Request edge register
  always_ff @(posedge PClk) begin
    if (Rst) begin
      btn_prev_r <= 1'b0;
    end else begin
      btn_prev_r <= BtnExtract;
    end
  end

  // Next-state decode; SwClear is applied in the state register
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (fs_s) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_ACCUM: begin
        if (term_fs_s) begin
          state_nxt_s = ST_DIV;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DIV: begin
        if (div_last_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_LOAD: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    trial_s = {rem_r, dvd_r[23]};
    if (trial_s >= {1'b0, DIVISOR}) begin
      q_bit_s   = 1'b1;
      rem_nxt_s = 24'(trial_s - {1'b0, DIVISOR});
    end else begin
      q_bit_s   = 1'b0;
      rem_nxt_s = trial_s[23:0];
    end
    q_nxt_s = {q_r[6:0], q_bit_s};
  end

  // Match bounds; hue either wraps modulo 256 or saturates like S and V
  always_comb begin
`ifdef COLOR_CTRL_HUE_WRAP_EN
    hue_low_s  = avg_r[23:16] - TOL_B;
    hue_high_s = avg_r[23:16] + TOL_B;
`else
    hue_low_s  = sat_low(avg_r[23:16]);
    hue_high_s = sat_high(avg_r[23:16]);
`endif
    low_s  = {hue_low_s, sat_low(avg_r[15:8]), sat_low(avg_r[7:0])};
    high_s = {hue_high_s, sat_high(avg_r[15:8]), sat_high(avg_r[7:0])};
  end

  // Sequencer state, window accumulators and serial divider
  always_ff @(posedge PClk) begin
    if (Rst || SwClear) begin
      state_r <= ST_IDLE;
      frm_r   <= 4'd0;
      sum_h_r <= 24'd0;
      sum_s_r <= 24'd0;
      sum_v_r <= 24'd0;
      dvd_r   <= 24'd0;
      rem_r   <= 24'd0;
      q_r     <= 8'd0;
      bit_r   <= 5'd0;
      ch_r    <= 2'd0;
      avg_r   <= 24'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_ARM: begin
          frm_r <= 4'd0;
          if (fs_s && in_win_s) begin
            sum_h_r <= {16'd0, HSV24[23:16]};
            sum_s_r <= {16'd0, HSV24[15:8]};
            sum_v_r <= {16'd0, HSV24[7:0]};
          end else begin
            sum_h_r <= 24'd0;
            sum_s_r <= 24'd0;
            sum_v_r <= 24'd0;
          end
        end
        ST_ACCUM: begin
          if (term_fs_s) begin
            frm_r <= frm_inc_s;
            dvd_r <= sum_h_r;
            rem_r <= 24'd0;
            bit_r <= 5'd0;
            ch_r  <= 2'd0;
          end else begin
            if (fs_s) begin
              frm_r <= frm_inc_s;
            end
            if (in_win_s) begin
              sum_h_r <= sum_h_r + {16'd0, HSV24[23:16]};
              sum_s_r <= sum_s_r + {16'd0, HSV24[15:8]};
              sum_v_r <= sum_v_r + {16'd0, HSV24[7:0]};
            end
          end
        end
        ST_DIV: begin
          q_r <= q_nxt_s;
          if (bit_r == 5'd23) begin
            // Channel finished: the low 8 quotient bits are the whole quotient
            bit_r <= 5'd0;
            rem_r <= 24'd0;
            ch_r  <= ch_r + 2'd1;
            case (ch_r)
              2'd0: begin
                avg_r[23:16] <= q_nxt_s;
                dvd_r        <= sum_s_r;
              end
              2'd1: begin
                avg_r[15:8] <= q_nxt_s;
                dvd_r       <= sum_v_r;
              end
              default: begin
                avg_r[7:0] <= q_nxt_s;
                dvd_r      <= 24'd0;
              end
            endcase
          end else begin
            bit_r <= bit_r + 5'd1;
            rem_r <= rem_nxt_s;
            dvd_r <= {dvd_r[22:0], 1'b0};
          end
        end
        default: begin
          frm_r <= frm_r;
        end
      endcase
    end
  end

  // Published results and status; old results stay valid until the next load
  always_ff @(posedge PClk) begin
    if (Rst || SwClear) begin
      HsvRef   <= 24'hFFFFFF;
      HsvLow   <= 24'hFFFFFF;
      HsvHigh  <= 24'h000000;
      RefValid <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else if (state_r == ST_LOAD) begin
      HsvRef   <= avg_r;
      HsvLow   <= low_s;
      HsvHigh  <= high_s;
      RefValid <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b1;
    end else begin
      Done <= 1'b0;
      Busy <= Busy || ((state_r == ST_IDLE) && rise_s);
    end
  end

endmodule

// File: tb/tb_color_extract_ctrl.sv
// Self-checking bench for color_extract_ctrl on a scaled-down 10x8 raster with a 4x3 window.
module tb_color_extract_ctrl;

  localparam int HTOT   = 10;
  localparam int VTOT   = 8;
  localparam int FLEN   = HTOT * VTOT;
  localparam int X0     = 3;
  localparam int Y0     = 2;
  localparam int W      = 4;
  localparam int H      = 3;
  localparam int NFRM   = 4;
  localparam int TOLV   = 16;
  localparam int NPIX   = W * H * NFRM;
`ifdef COLOR_CTRL_HUE_WRAP_EN
  localparam bit HUE_WRAP = 1'b1;
`else
  localparam bit HUE_WRAP = 1'b0;
`endif

  logic        PClk = 1'b0;
  logic        Rst = 1'b1;
  logic [11:0] VtcHCnt = 12'd0;
  logic [11:0] VtcVCnt = 12'd0;
  logic [23:0] HSV24 = 24'd0;
  logic        BtnExtract = 1'b0;
  logic        SwClear = 1'b0;
  logic        Busy;
  logic        Done;
  logic        RefValid;
  logic [23:0] HsvRef;
  logic [23:0] HsvLow;
  logic [23:0] HsvHigh;

  color_extract_ctrl #(
    .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .WIN_H(H), .FRAMES(NFRM), .TOL(TOLV)
  ) dut (
    .PClk(PClk), .Rst(Rst), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt), .HSV24(HSV24),
    .BtnExtract(BtnExtract), .SwClear(SwClear), .Busy(Busy), .Done(Done),
    .RefValid(RefValid), .HsvRef(HsvRef), .HsvLow(HsvLow), .HsvHigh(HsvHigh)
  );

  always #5 PClk = ~PClk;

  typedef struct {
    int          kind;
    logic [23:0] c;
    logic [23:0] e_ref;
    logic [23:0] e_low;
    logic [23:0] e_high;
  } vec_t;

  vec_t        vecs [5];
  logic [23:0] rnd_mem [0:7][0:FLEN-1];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cyc_done = 0;
  int          cur_kind = 0;
  logic [23:0] cur_c = 24'd0;
  logic [23:0] prev_ref = 24'hFFFFFF;
  logic        prev_valid = 1'b0;

  function automatic bit in_win(input int h, input int v);
    return (h >= X0) && (h < X0 + W) && (v >= Y0) && (v < Y0 + H);
  endfunction

  // kind 0: constant, 1: window value on white, 2: odd frames c / even frames 0, 3: random
  function automatic logic [23:0] pix(input int kind, input logic [23:0] c,
                                      input int f, input int h, input int v);
    case (kind)
      0:       return c;
      1:       return in_win(h, v) ? c : 24'hFFFFFF;
      2:       return (f % 2 == 1) ? c : 24'h000000;
      default: return rnd_mem[f % 8][v * HTOT + h];
    endcase
  endfunction

  function automatic logic [23:0] model_avg(input int f0);
    int s [3];
    logic [23:0] p;
    s = '{0, 0, 0};
    for (int f = f0; f < f0 + NFRM; f++)
      for (int v = 0; v < VTOT; v++)
        for (int h = 0; h < HTOT; h++)
          if (in_win(h, v)) begin
            p = pix(cur_kind, cur_c, f, h, v);
            s[0] += int'(p[23:16]);
            s[1] += int'(p[15:8]);
            s[2] += int'(p[7:0]);
          end
    return {8'(s[0] / NPIX), 8'(s[1] / NPIX), 8'(s[2] / NPIX)};
  endfunction

  function automatic logic [23:0] model_bound(input logic [23:0] r, input bit upper);
    logic [23:0] o;
    int c;
    int t;
    o = 24'd0;
    for (int i = 0; i < 3; i++) begin
      c = int'(r[8*i +: 8]);
      t = upper ? c + TOLV : c - TOLV;
      if (i == 2 && HUE_WRAP) o[8*i +: 8] = 8'(t & 255);
      else if (t < 0)         o[8*i +: 8] = 8'd0;
      else if (t > 255)       o[8*i +: 8] = 8'd255;
      else                    o[8*i +: 8] = 8'(t);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc_done);
    end
  endtask

  task automatic step();
    VtcHCnt = 12'(cyc % HTOT);
    VtcVCnt = 12'((cyc / HTOT) % VTOT);
    HSV24   = pix(cur_kind, cur_c, cyc / FLEN, cyc % HTOT, (cyc / HTOT) % VTOT);
    @(posedge PClk);
    #1;
    cyc_done = cyc;
    cyc++;
  endtask

  task automatic run_extract(input string nm, input bit use_model, input logic [23:0] t_ref,
                             input logic [23:0] t_low, input logic [23:0] t_high,
                             input bit div_rise);
    int f;
    int t_fs;
    int lim;
    int seen;
    int pulses;
    logic [23:0] e_ref;
    logic [23:0] e_low;
    logic [23:0] e_high;
    while (cyc % FLEN != 40) step();
    f = cyc / FLEN;
    BtnExtract = 1'b1;
    step();
    step();
    chk({nm, "_busy_rise"}, 32'(Busy), 32'd1);
    BtnExtract = 1'b0;
    t_fs = FLEN * (f + 1 + NFRM);
    if (use_model) begin
      e_ref  = model_avg(f + 1);
      e_low  = model_bound(e_ref, 1'b0);
      e_high = model_bound(e_ref, 1'b1);
    end else begin
      e_ref  = t_ref;
      e_low  = t_low;
      e_high = t_high;
    end
    lim    = div_rise ? t_fs + 73 + NFRM * FLEN + 100 : t_fs + 80;
    seen   = -1;
    pulses = 0;
    while (cyc <= lim) begin
      if (div_rise && cyc == t_fs + 10) BtnExtract = 1'b1;
      else if (cyc == t_fs + 12)        BtnExtract = 1'b0;
      step();
      if (Done) begin
        pulses++;
        if (seen < 0) seen = cyc_done;
      end
      if (cyc_done == t_fs + 40) begin
        chk({nm, "_hold_ref"}, HsvRef, prev_ref);
        chk({nm, "_hold_valid"}, 32'(RefValid), 32'(prev_valid));
        chk({nm, "_busy_div"}, 32'(Busy), 32'd1);
      end
    end
    chk({nm, "_done_cycle"}, seen, t_fs + 73);
    chk({nm, "_done_pulses"}, pulses, 32'd1);
    chk({nm, "_ref"}, HsvRef, e_ref);
    chk({nm, "_low"}, HsvLow, e_low);
    chk({nm, "_high"}, HsvHigh, e_high);
    chk({nm, "_valid"}, 32'(RefValid), 32'd1);
    chk({nm, "_busy_end"}, 32'(Busy), 32'd0);
    prev_ref   = e_ref;
    prev_valid = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int pulses;
    vecs[0] = '{0, 24'h4080C0, 24'h4080C0, 24'h3070B0, 24'h5090D0};
    vecs[1] = '{0, 24'h05FA80, 24'h05FA80, HUE_WRAP ? 24'hF5EA70 : 24'h00EA70, 24'h15FF90};
    vecs[2] = '{1, 24'h102030, 24'h102030, 24'h001020, 24'h203040};
    vecs[3] = '{2, 24'h030303, 24'h010101, HUE_WRAP ? 24'hF10000 : 24'h000000, 24'h111111};
    vecs[4] = '{0, 24'h00FF00, 24'h00FF00, HUE_WRAP ? 24'hF0EF00 : 24'h00EF00, 24'h10FF10};

    Rst = 1'b1;
    repeat (3) step();
    chk("rst_ref", HsvRef, 24'hFFFFFF);
    chk("rst_low", HsvLow, 24'hFFFFFF);
    chk("rst_high", HsvHigh, 24'h000000);
    chk("rst_valid", 32'(RefValid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    Rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cur_kind = vecs[i].kind;
      cur_c    = vecs[i].c;
      run_extract($sformatf("vec%0d", i), 1'b0, vecs[i].e_ref, vecs[i].e_low,
                  vecs[i].e_high, 1'b0);
    end

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < FLEN; b++)
          rnd_mem[a][b] = 24'($urandom);
      cur_kind = 3;
      run_extract($sformatf("rand%0d", r), 1'b1, 24'd0, 24'd0, 24'd0, 1'b0);
    end

    // Second request rise during DIV must be ignored
    cur_kind = 0;
    cur_c    = 24'h204060;
    run_extract("divrise", 1'b0, 24'h204060, 24'h103050, 24'h305070, 1'b1);

    // SwClear in the middle of accumulation discards the extraction
    while (cyc % FLEN != 40) step();
    f = cyc / FLEN;
    BtnExtract = 1'b1;
    step();
    step();
    BtnExtract = 1'b0;
    while (cyc < FLEN * (f + 2) + 20) step();
    chk("clr_busy_before", 32'(Busy), 32'd1);
    SwClear = 1'b1;
    step();
    chk("clr_busy", 32'(Busy), 32'd0);
    chk("clr_ref", HsvRef, 24'hFFFFFF);
    chk("clr_low", HsvLow, 24'hFFFFFF);
    chk("clr_high", HsvHigh, 24'h000000);
    chk("clr_valid", 32'(RefValid), 32'd0);
    step();
    step();
    SwClear = 1'b0;
    pulses = 0;
    while (cyc < FLEN * (f + 1 + NFRM) + 100) begin
      step();
      if (Done) pulses++;
    end
    chk("clr_no_done", pulses, 32'd0);
    chk("clr_idle_busy", 32'(Busy), 32'd0);
    prev_ref   = 24'hFFFFFF;
    prev_valid = 1'b0;

    cur_kind = 1;
    cur_c    = 24'h7F1020;
    run_extract("after_clr", 1'b0, 24'h7F1020, 24'h6F0010, 24'h8F2030, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
